// File: rtl/tune_seq_pkg.sv
// Shared types, default settle times and counter sizing for the tune sequencer.
package tune_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    MUTE,
    BAND,
    TUNE,
    UNMUTE
  } tuneState_t;

  localparam int DEFAULT_MUTE_CYCLES  = 64;
  localparam int DEFAULT_RELAY_CYCLES = 50000;
  localparam int DEFAULT_PLL_CYCLES   = 2000;

  // Width of the shared settle counter: clog2 of the longest wait, never below 1 bit.
  function automatic int counterWidth(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/settle_timer.sv
// Loadable down-counter; done is high whenever the count has reached zero.
module settle_timer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] loadValue,
  output logic             done
);

  logic [WIDTH-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= loadValue;
    end else if (count != '0) begin
      count <= count - WIDTH'(1);
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/tune_sequencer.sv
// Applies SPI control registers to NCO, band relays and TX path, muting TX around
// band/T-R changes and letting relays and PLL settle before TX returns.
module tune_sequencer
  import tune_seq_pkg::*;
#(
  parameter int MUTE_CYCLES  = DEFAULT_MUTE_CYCLES,
  parameter int RELAY_CYCLES = DEFAULT_RELAY_CYCLES,
  parameter int PLL_CYCLES   = DEFAULT_PLL_CYCLES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] reqFreq,
  input  logic [15:0] reqPhase,
  input  logic        reqNcoEn,
  input  logic [7:0]  reqBand,
  input  logic        reqTx,
  input  logic        txInhibit,
  output logic [31:0] freqControl,
  output logic [15:0] phaseOffset,
  output logic        ncoEnable,
  output logic [7:0]  bandSelect,
  output logic        txEnable,
  output logic        txMute,
  output logic        busy,
  output logic        seqDone
);

  localparam int CW = counterWidth(MUTE_CYCLES, RELAY_CYCLES, PLL_CYCLES);
  localparam logic [CW-1:0] MUTE_LOAD  = CW'(MUTE_CYCLES - 1);
  localparam logic [CW-1:0] RELAY_LOAD = CW'(RELAY_CYCLES - 1);
  localparam logic [CW-1:0] PLL_LOAD   = CW'(PLL_CYCLES - 1);

  tuneState_t    state, nextState;
  logic [7:0]    pendBand;
  logic          pendTx;
  logic          timerLoad, timerDone;
  logic [CW-1:0] timerLoadValue;
  logic          effTx, bandTxDiff, ncoDiff;

  assign effTx      = reqTx & ~txInhibit;
  assign bandTxDiff = (reqBand != bandSelect) || (effTx != txEnable);
  assign ncoDiff    = (reqFreq != freqControl) || (reqPhase != phaseOffset) ||
                      (reqNcoEn != ncoEnable);

  settle_timer #(.WIDTH(CW)) uTimer (
    .clk       (clk),
    .rst       (rst),
    .load      (timerLoad),
    .loadValue (timerLoadValue),
    .done      (timerDone)
  );

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    nextState      = state;
    timerLoad      = 1'b0;
    timerLoadValue = '0;
    case (state)
      IDLE: if (bandTxDiff) begin
        nextState      = MUTE;
        timerLoad      = 1'b1;
        timerLoadValue = MUTE_LOAD;
      end
      MUTE: if (timerDone) begin
        nextState      = BAND;
        timerLoad      = 1'b1;
        timerLoadValue = RELAY_LOAD;
      end
      BAND: if (timerDone) begin
        nextState      = TUNE;
        timerLoad      = 1'b1;
        timerLoadValue = PLL_LOAD;
      end
      TUNE:    if (timerDone) nextState = UNMUTE;
      UNMUTE:  nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      pendBand    <= '0;
      pendTx      <= 1'b0;
      freqControl <= '0;
      phaseOffset <= '0;
      ncoEnable   <= 1'b0;
      bandSelect  <= '0;
      txEnable    <= 1'b0;
    end else begin
      state <= nextState;
      case (state)
        IDLE: begin
          if (bandTxDiff) begin
            pendBand <= reqBand;
            pendTx   <= effTx;
            txEnable <= 1'b0;
          end else if (ncoDiff) begin
            freqControl <= reqFreq;
            phaseOffset <= reqPhase;
            ncoEnable   <= reqNcoEn;
          end
        end
        MUTE: if (timerDone) bandSelect <= pendBand;
        BAND: if (timerDone) begin
          freqControl <= reqFreq;
          phaseOffset <= reqPhase;
          ncoEnable   <= reqNcoEn;
        end
        TUNE: if (timerDone) txEnable <= pendTx & ~txInhibit;
        default: ;
      endcase
      // A fault inhibit wins over anything the sequence decided this cycle.
      if (txInhibit) txEnable <= 1'b0;
    end
  end

  assign txMute  = (state == MUTE) || (state == BAND) || (state == TUNE);
  assign busy    = (state != IDLE);
  assign seqDone = (state == UNMUTE);

endmodule
